// File: rtl/virq_injector_pkg.sv
// Shared definitions for the virtual interrupt injector: FSM encoding,
// hypervisor register select codes and status bit positions.
package virq_injector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_ACK    = 2'd2,
    ST_POP    = 2'd3
  } state_t;

  localparam logic [1:0] SEL_PUSH  = 2'd0;
  localparam logic [1:0] SEL_CTRL  = 2'd1;
  localparam logic [1:0] SEL_FLUSH = 2'd2;

  localparam int STAT_STALE = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;
  localparam int STAT_OVF   = 4;

  // Occupancy field is only four bits wide, so a 16-deep queue reads as 15.
  function automatic logic [3:0] sat_occ(input logic [4:0] n);
    return (n > 5'd15) ? 4'hf : n[3:0];
  endfunction

endpackage

// File: rtl/virq_fifo.sv
// DEPTH x 8 synchronous vector FIFO with wrap-bit pointers; push when full
// and pop when empty are ignored, and flush returns both pointers to zero.
module virq_fifo #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [7:0]  wdata,
  output logic [7:0]  head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/virq_injector.sv
// Injects hypervisor-queued IM2 vectors into the guest Z80: raises INT while
// the guest runs untrapped, answers the INTA cycle with the head vector, pops it.
module virq_injector
  import virq_injector_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic       trap_state,
  input  logic       virtual_enabled,
  input  logic       reg_wr,
  input  logic [1:0] reg_sel,
  input  logic [7:0] wdata,
  output logic       int_n,
  output logic       vec_oe,
  output logic [7:0] vec_data,
  output logic [7:0] status,
  output state_t     dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  state_t        state;
  logic          enable;
  logic          overflow;
  logic          stale;
  logic [TW-1:0] to_cnt;

  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [AW:0]   count;

  logic wr_push, wr_ctrl, wr_flush;
  logic fifo_flush, fifo_pop, deliver, inta;

  assign wr_push    = reg_wr && (reg_sel == SEL_PUSH);
  assign wr_ctrl    = reg_wr && (reg_sel == SEL_CTRL);
  assign wr_flush   = reg_wr && (reg_sel == SEL_FLUSH);
  // The head vector is on the bus during ACK, so a queue flush must wait.
  assign fifo_flush = wr_flush && wdata[1] && (state != ST_ACK);
  assign fifo_pop   = (state == ST_POP);
  assign deliver    = enable && virtual_enabled && !trap_state && !empty;
  assign inta       = !m1_n && !iorq_n;

  virq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wdata   (wdata),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) enable <= wdata[0];
      if (wr_flush && wdata[0]) overflow <= 1'b0;
      else if (wr_push && full) overflow <= 1'b1;
    end
  end

  // Guest handshake: int_n low requests service; the guest acknowledges with
  // M1 and IORQ low in the same sampled cycle, and the vector stays driven
  // until IORQ is sampled high again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      int_n    <= 1'b1;
      vec_oe   <= 1'b0;
      vec_data <= 8'h00;
      to_cnt   <= '0;
      stale    <= 1'b0;
    end else begin
      if (wr_flush && wdata[0]) stale <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (deliver) begin
            state <= ST_ASSERT;
            int_n <= 1'b0;
          end
        end
        ST_ASSERT: begin
          if (inta) begin
            state    <= ST_ACK;
            int_n    <= 1'b1;
            vec_oe   <= 1'b1;
            vec_data <= head;
          end else if (!deliver) begin
            state  <= ST_IDLE;
            int_n  <= 1'b1;
            to_cnt <= '0;
          end else if (to_cnt != TW'(TIMEOUT - 1)) begin
            // Stale fires only on the step into the terminal count, so a clear
            // while still waiting is not immediately undone.
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TW'(TIMEOUT - 2)) stale <= 1'b1;
          end
        end
        ST_ACK: begin
          if (iorq_n) begin
            state  <= ST_POP;
            vec_oe <= 1'b0;
          end
        end
        ST_POP: begin
          state  <= ST_IDLE;
          to_cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign status    = {stale, full, empty, overflow, sat_occ(5'(count))};
  assign dbg_state = state;

endmodule

// File: doc/virq_injector.md
Name: virq_injector

Overview:
- Delivers hypervisor-posted virtual interrupts into the guest Z80. This is the inverse path of the trap/NMI intercept, which pulls system IRQs out to the hypervisor.
- The hypervisor queues 8-bit IM2 vectors. The block asserts guest INT only while the guest runs untrapped, answers the INTA cycle by driving the queued vector, then pops it.
- Sits beside the trap-mode controller and consumes its trap_state and virtual_enabled outputs.

Parameters:
- DEPTH, 4, vector FIFO entries (power of two, 2..16).
- TIMEOUT, 4096, clk cycles of unacknowledged INT before the stale flag sets (≥2).

Ports:
- clk  in  1  Z80 CPU clock; all Z80 bus inputs sampled on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m1_n  in  1  Z80 M1.
- iorq_n  in  1  Z80 IORQ.
- trap_state  in  1  high while the hypervisor owns the CPU.
- virtual_enabled  in  1  virtualization on.
- reg_wr  in  1  one-cycle hypervisor register write strobe.
- reg_sel  in  2  0 = push vector, 1 = control, 2 = clear-stale/flush.
- wdata  in  8  write data.
- int_n  out  1  guest interrupt request, active-low.
- vec_oe  out  1  drive vec_data onto the data bus.
- vec_data  out  8  vector at FIFO head.
- status  out  8  [7] stale, [6] full, [5] empty, [4] overflow, [3:0] occupancy (saturates at 15).

Behaviour:
- Reset values:
  - int_n=1, vec_oe=0, vec_data=0, status=8'h20.
  - FIFO empty; control enable=0; state IDLE; timeout counter 0.
- Control register: wdata[0] = enable. Other bits are ignored and read as 0.
- Push (reg_sel=0):
  - If not full, write wdata at the tail; occupancy+1.
  - If full, drop the data and set overflow (sticky).
- Flush (reg_sel=2):
  - wdata[0] clears stale and overflow.
  - wdata[1] empties the FIFO, but is ignored while in ACK.
- Pointer arithmetic: pointers are log2(DEPTH)+1 bits, wrap modulo 2*DEPTH. Full when the MSBs differ and the rest match.
- Gate: deliver = enable && virtual_enabled && !trap_state && !empty.
- IDLE:
  - int_n=1.
  - If deliver → ASSERT, int_n=0 from the next cycle.
- ASSERT:
  - int_n=0; the timeout counter increments each cycle.
  - If the counter reaches TIMEOUT-1, set stale; the counter holds and INT stays asserted.
  - If the gate drops (trap entered, disabled, flushed) → IDLE, counter cleared, FIFO untouched.
  - If the sampled m1_n=0 and iorq_n=0 in the same cycle → ACK. This takes priority over gate-drop in the same cycle.
- ACK:
  - vec_oe=1, vec_data = head; int_n returns to 1 on ACK entry.
  - The head is frozen: a push in ACK goes to the tail only.
  - When iorq_n is sampled 1 → POP (vec_oe=0 the same cycle).
- POP:
  - Advance head, occupancy-1; counter cleared.
  - Next state IDLE, so there is a minimum one-cycle INT gap between vectors.
- Simultaneous push and pop: occupancy is unchanged and full is never falsely set.
- reset_n asserted mid-ACK: vec_oe drops immediately (asynchronous) and every item is reset per the reset values above.
- Plain M1 fetches (iorq_n=1) and I/O cycles (m1_n=1) never count as acknowledge.

Decomposition:
- Shared package: state encoding (IDLE, ASSERT, ACK, POP), reg_sel codes, status bit indices.
- One sub-module: virq_fifo, a parameterised DEPTH×8 synchronous FIFO.
  - Ports: push, pop, flush, data in, head out, full, empty, count.
  - Asynchronous active-low reset.

Test Plan:
- enable=1, trap_state=0, push 8'hA4 → int_n=0 two cycles later. Drive m1_n=0 & iorq_n=0 → vec_oe=1, vec_data=8'hA4. iorq_n=1 → vec_oe=0, status=8'h20.
- Push 5 vectors with DEPTH=4 → status=8'h54 (full, overflow, count 4). First four acknowledged in order; fifth never appears.
- Raise trap_state during ASSERT → int_n=1 next cycle, count unchanged. Drop trap_state → int_n=0 again, same vector delivered.
- No acknowledge for TIMEOUT cycles → status[7]=1, int_n stays 0. Write reg_sel=2, wdata=1 → stale cleared.
- Push 8'h10, 8'h20 → two INTA cycles yield 10 then 20, with int_n=1 for ≥1 cycle between them. Pull reset_n low during the second ACK → vec_oe=0 asynchronously, status=8'h20.
- virtual_enabled=0 with a queued vector → int_n stays 1; plain M1 fetches do not pop the vector.
